id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fwd_unit.sv | 34 +++
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the ALU opcode encoding used by
// the ID/EX stage and the ALU.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one ALU source: EX/MEM result wins over
// MEM/WB data, and x0 is never forwarded.
module fwd_unit #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int RA_W = cpu_pkg::RA_W
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] rs_data,
    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    logic rs_nonzero_s;

    assign rs_nonzero_s = (rs != {RA_W{1'b0}});

    // Priority mux: youngest producer first, register file copy last
    always_comb begin
        fwd_data = rs_data;
        if (rs_nonzero_s && exm_reg_write && (exm_rd == rs)) begin
            fwd_data = exm_result;
        end else if (rs_nonzero_s && wb_reg_write && (wb_rd == rs)) begin
            fwd_data = wb_data;
        end else begin
            fwd_data = rs_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/bubble
// insertion and operand forwarding into the EX stage.
module id_ex_stage #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int RA_W = cpu_pkg::RA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [3:0]      id_alu_ctrl,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            id_is_load,
    input  logic            id_reg_write,
    input  logic            flush,
    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_ctrl,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_is_load,
    output logic [XLEN-1:0] alu_data_1,
    output logic [XLEN-1:0] alu_data_2
);

    import cpu_pkg::*;

    logic            stall_s;
    logic            bubble_s;
    logic [XLEN-1:0] rs1_in_s;
    logic [XLEN-1:0] rs2_in_s;
    logic [XLEN-1:0] fwd2_s;

    logic            ex_valid_r;
    logic [3:0]      ex_alu_ctrl_r;
    logic [RA_W-1:0] ex_rd_r;
    logic            ex_reg_write_r;
    logic            ex_is_load_r;
    logic [RA_W-1:0] rs1_r;
    logic [RA_W-1:0] rs2_r;
    logic [XLEN-1:0] rs1_data_r;
    logic [XLEN-1:0] rs2_data_r;
    logic [XLEN-1:0] imm_r;
    logic            use_imm_r;

    // Load-use hazard: the loaded value is not available until after EX
    always_comb begin
        stall_s = 1'b0;
        if (ex_valid_r && ex_is_load_r && (ex_rd_r != {RA_W{1'b0}}) && id_valid && !flush) begin
            if ((id_rs1 == ex_rd_r) || (!id_use_imm && (id_rs2 == ex_rd_r))) begin
                stall_s = 1'b1;
            end else begin
                stall_s = 1'b0;
            end
        end else begin
            stall_s = 1'b0;
        end
    end

    assign stall    = stall_s;
    assign bubble_s = flush | stall_s;

    // Same-cycle writeback bypass so the latched operand is never stale
    always_comb begin
        rs1_in_s = id_rs1_data;
        rs2_in_s = id_rs2_data;
        if (wb_reg_write && (wb_rd == id_rs1) && (id_rs1 != {RA_W{1'b0}})) begin
            rs1_in_s = wb_data;
        end else begin
            rs1_in_s = id_rs1_data;
        end
        if (wb_reg_write && (wb_rd == id_rs2) && (id_rs2 != {RA_W{1'b0}})) begin
            rs2_in_s = wb_data;
        end else begin
            rs2_in_s = id_rs2_data;
        end
    end

    // Pipeline register; a bubble kills only the control that has side effects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r     <= 1'b0;
            ex_alu_ctrl_r  <= ALU_ADD;
            ex_rd_r        <= {RA_W{1'b0}};
            ex_reg_write_r <= 1'b0;
            ex_is_load_r   <= 1'b0;
            rs1_r          <= {RA_W{1'b0}};
            rs2_r          <= {RA_W{1'b0}};
            rs1_data_r     <= {XLEN{1'b0}};
            rs2_data_r     <= {XLEN{1'b0}};
            imm_r          <= {XLEN{1'b0}};
            use_imm_r      <= 1'b0;
        end else begin
            ex_alu_ctrl_r <= id_alu_ctrl;
            ex_rd_r       <= id_rd;
            rs1_r         <= id_rs1;
            rs2_r         <= id_rs2;
            rs1_data_r    <= rs1_in_s;
            rs2_data_r    <= rs2_in_s;
            imm_r         <= id_imm;
            use_imm_r     <= id_use_imm;
            if (bubble_s) begin
                ex_valid_r     <= 1'b0;
                ex_reg_write_r <= 1'b0;
                ex_is_load_r   <= 1'b0;
            end else begin
                ex_valid_r     <= id_valid;
                ex_reg_write_r <= id_reg_write & id_valid;
                ex_is_load_r   <= id_is_load & id_valid;
            end
        end
    end

    fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_1 (
        .rs            (rs1_r),
        .rs_data       (rs1_data_r),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_data      (alu_data_1)
    );

    fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_2 (
        .rs            (rs2_r),
        .rs_data       (rs2_data_r),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_data      (fwd2_s)
    );

    assign alu_data_2   = use_imm_r ? imm_r : fwd2_s;
    assign ex_valid     = ex_valid_r;
    assign ex_alu_ctrl  = ex_alu_ctrl_r;
    assign ex_rd        = ex_rd_r;
    assign ex_reg_write = ex_reg_write_r;
    assign ex_is_load   = ex_is_load_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios
// followed by random traffic against a slot-level reference model.
module tb_id_ex_stage;

    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_alu_ctrl = 4'd0;
    logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic [31:0] id_rs1_data = 32'd0, id_rs2_data = 32'd0, id_imm = 32'd0;
    logic        id_use_imm = 1'b0, id_is_load = 1'b0, id_reg_write = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  exm_rd = 5'd0, wb_rd = 5'd0;
    logic        exm_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [31:0] exm_result = 32'd0, wb_data = 32'd0;
    logic        stall, ex_valid, ex_reg_write, ex_is_load;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;
    logic [31:0] alu_data_1, alu_data_2;

    int n_total = 0;
    int n_bad   = 0;
    logic last_stall = 1'b0;

    // Reference view of the instruction currently sitting in EX
    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic        rw, ld, ui;
        logic [31:0] d1, d2, imm;
    } slot_t;
    slot_t m;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_is_load(id_is_load), .id_reg_write(id_reg_write),
        .flush(flush), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value an EX operand should take given the producers visible right now
    function automatic logic [31:0] ex_pick(input logic [4:0] rs, input logic [31:0] d);
        if (rs == 5'd0) return d;
        if (exm_reg_write && exm_rd == rs) return exm_result;
        if (wb_reg_write && wb_rd == rs) return wb_data;
        return d;
    endfunction

    function automatic logic [31:0] id_pick(input logic [4:0] rs, input logic [31:0] d);
        if (rs != 5'd0 && wb_reg_write && wb_rd == rs) return wb_data;
        return d;
    endfunction

    function automatic logic exp_stall();
        logic uses;
        uses = (id_rs1 == m.rd) || (!id_use_imm && id_rs2 == m.rd);
        return m.v && m.ld && (m.rd != 5'd0) && id_valid && !flush && uses;
    endfunction

    task automatic drive_id(input logic v, input logic [3:0] op, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] imm, input logic ui,
                            input logic ld, input logic rw);
        id_valid = v; id_alu_ctrl = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_use_imm = ui; id_is_load = ld; id_reg_write = rw;
    endtask

    task automatic drive_fw(input logic [4:0] erd, input logic erw, input logic [31:0] eres,
                            input logic [4:0] wrd, input logic wrw, input logic [31:0] wdat);
        exm_rd = erd; exm_reg_write = erw; exm_result = eres;
        wb_rd = wrd; wb_reg_write = wrw; wb_data = wdat;
    endtask

    // One clock: check combinational outputs, advance the model, check registers
    task automatic cycle();
        logic s;
        #1;
        s = exp_stall();
        last_stall = s;
        chk("stall", 32'(stall), 32'(s));
        chk("alu1", alu_data_1, ex_pick(m.rs1, m.d1));
        chk("alu2", alu_data_2, m.ui ? m.imm : ex_pick(m.rs2, m.d2));
        @(posedge clk);
        m.op = id_alu_ctrl; m.rd = id_rd; m.rs1 = id_rs1; m.rs2 = id_rs2;
        m.d1 = id_pick(id_rs1, id_rs1_data); m.d2 = id_pick(id_rs2, id_rs2_data);
        m.imm = id_imm; m.ui = id_use_imm;
        if (flush || s) begin
            m.v = 1'b0; m.rw = 1'b0; m.ld = 1'b0;
        end else begin
            m.v = id_valid; m.rw = id_reg_write & id_valid; m.ld = id_is_load & id_valid;
        end
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m.v));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("ex_is_load", 32'(ex_is_load), 32'(m.ld));
        chk("ex_rd", 32'(ex_rd), 32'(m.rd));
        chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m.op));
        @(negedge clk);
    endtask

    initial begin
        m = '0;
        // Reset with a valid instruction waiting in decode
        drive_id(1'b1, 4'd5, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1, 1'b1);
        #2;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_rw", 32'(ex_reg_write), 32'd0);
        chk("rst_ld", 32'(ex_is_load), 32'd0);
        chk("rst_op", 32'(ex_alu_ctrl), 32'(ALU_ADD));
        chk("rst_rd", 32'(ex_rd), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_alu1", alu_data_1, 32'd0);
        chk("rst_alu2", alu_data_2, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("stall_after_rst", 32'(stall), 32'd0);

        // ADD x5 then consume x5 with the EX/MEM result forwarded
        drive_id(1'b1, 4'd0, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        drive_id(1'b1, 4'd0, 5'd5, 5'd0, 5'd6, 32'hDEAD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        drive_id(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_fw(5'd5, 1'b1, 32'h1234, 5'd0, 1'b0, 32'h0);
        #1;
        chk("exm_fwd_alu1", alu_data_1, 32'h1234);
        cycle();

        // Both forwarding sources match: EX/MEM wins
        drive_fw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        drive_id(1'b1, 4'd1, 5'd0, 5'd7, 5'd8, 32'h0, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        drive_id(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_fw(5'd7, 1'b1, 32'hA, 5'd7, 1'b1, 32'hB);
        #1;
        chk("dual_match_alu2", alu_data_2, 32'hA);
        cycle();

        // Load x3 then ADD rs1=x3: one bubble, then issue with WB forwarding
        drive_fw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        drive_id(1'b1, 4'd0, 5'd1, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1);
        cycle();
        drive_id(1'b1, 4'd0, 5'd3, 5'd0, 5'd9, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("load_use_stall", 32'(stall), 32'd1);
        cycle();
        chk("bubble_valid", 32'(ex_valid), 32'd0);
        chk("bubble_rw", 32'(ex_reg_write), 32'd0);
        #1;
        chk("stall_released", 32'(stall), 32'd0);
        cycle();
        drive_id(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_fw(5'd0, 1'b0, 32'h0, 5'd3, 1'b1, 32'h77);
        #1;
        chk("add_issued", 32'(ex_valid), 32'd1);
        chk("wb_fwd_alu1", alu_data_1, 32'h77);
        cycle();

        // Flush coincident with a load-use hazard
        drive_fw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        drive_id(1'b1, 4'd0, 5'd1, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle();
        drive_id(1'b1, 4'd0, 5'd3, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_no_stall", 32'(stall), 32'd0);
        cycle();
        flush = 1'b0;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_rw", 32'(ex_reg_write), 32'd0);

        // x0 is never forwarded
        drive_id(1'b1, 4'd0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        drive_id(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_fw(5'd0, 1'b1, 32'hFFFF, 5'd0, 1'b1, 32'hEEEE);
        #1;
        chk("x0_alu1", alu_data_1, 32'h0);
        cycle();

        // Reset asserted while a load-use stall is in progress
        drive_fw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        drive_id(1'b1, 4'd0, 5'd1, 5'd0, 5'd4, 32'h9, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle();
        drive_id(1'b1, 4'd0, 5'd4, 5'd0, 5'd2, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        m = '0;
        chk("midrst_valid", 32'(ex_valid), 32'd0);
        chk("midrst_ld", 32'(ex_is_load), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_rd", 32'(ex_rd), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_stall = 1'b0;
        cycle();

        // Random traffic; decode holds its instruction while stalled
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                id_valid     = ($urandom_range(0, 3) != 0);
                id_alu_ctrl  = 4'($urandom_range(0, 15));
                id_rs1       = 5'($urandom_range(0, 7));
                id_rs2       = 5'($urandom_range(0, 7));
                id_rd        = 5'($urandom_range(0, 7));
                id_rs1_data  = $urandom;
                id_rs2_data  = $urandom;
                id_imm       = $urandom;
                id_use_imm   = ($urandom_range(0, 1) != 0);
                id_is_load   = ($urandom_range(0, 2) == 0);
                id_reg_write = ($urandom_range(0, 3) != 0);
            end
            flush         = ($urandom_range(0, 7) == 0);
            exm_rd        = 5'($urandom_range(0, 7));
            exm_reg_write = ($urandom_range(0, 1) != 0);
            exm_result    = $urandom;
            wb_rd         = 5'($urandom_range(0, 7));
            wb_reg_write  = ($urandom_range(0, 1) != 0);
            wb_data       = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
